// File: rtl/choose_with_age_queue_n.sv
// ---------------------------------------------------------------------------
// choose_with_age_queue_n
//
// N-channel oldest-first selector with one holding slot per channel.
// Every accepted request is stamped with a compact relative age (0 = oldest).
// The occupied slots always carry the ages 0..occ_cnt-1, each exactly once.
// The slot with age 0 is presented on the output port. On each departure
// every surviving age drops by one, so ages never wrap.
//
// Handshake: a transfer happens on a rising edge where valid && ready. This
// holds on every channel input (in_vld/in_rdy) and on the output port
// (out_vld/out_rdy). Once out_vld is high, out_idx/out_data stay stable until
// the transfer.
//
// Optional feature (macro CHOOSE_WITH_AGE_BYPASS_EN):
//   When this macro is defined, the slot being drained this cycle can be
//   refilled on the same edge. In that build in_rdy depends combinationally
//   on out_rdy. When the macro is not defined, a drained slot accepts again
//   from the next cycle.
//
// Parameters:
//   N       number of channels / slots (>= 2)
//   DATA_W  payload width per channel
//   AGE_W   relative age width, $clog2(N) (derived, do not override)
//   CNT_W   occupancy count width, $clog2(N+1) (derived, do not override)
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset, discards all held requests
//   in_vld    [N]         per-channel request valid
//   in_rdy    [N]         per-channel slot can accept
//   in_data   [N*DATA_W]  per-channel payload, channel i at [i*DATA_W +: DATA_W]
//   out_vld               oldest slot presented
//   out_rdy               consumer accepts
//   out_data  [DATA_W]    payload of the oldest slot (0 when empty)
//   out_idx   [AGE_W]     channel index of the oldest slot (0 when empty)
//   occ_cnt   [CNT_W]     number of occupied slots
// ---------------------------------------------------------------------------
module choose_with_age_queue_n #(
    parameter int N      = 3,
    parameter int DATA_W = 8,
    parameter int AGE_W  = $clog2(N),
    parameter int CNT_W  = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          in_vld,
    output logic [N-1:0]          in_rdy,
    input  logic [N*DATA_W-1:0]   in_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_W-1:0]     out_data,
    output logic [AGE_W-1:0]      out_idx,
    output logic [CNT_W-1:0]      occ_cnt
);

    // Per-slot state
    logic [N-1:0]        occ_q;
    logic [AGE_W-1:0]    age_q  [N];
    logic [DATA_W-1:0]   data_q [N];

    // Derived combinational signals
    logic [N-1:0]        sel_hit;    // one-hot: occupied slot with age 0
    logic [AGE_W-1:0]    sel_idx;
    logic                dep;        // departure on this edge
    logic [N-1:0]        acc;        // per-channel acceptance on this edge
    logic [AGE_W-1:0]    new_age [N];

    // Occupancy count
    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < N; i++) begin
            occ_cnt = occ_cnt + CNT_W'(occ_q[i]);
        end
    end

    // Find the oldest slot. Ages of occupied slots are unique, so at most one
    // slot matches. The payload is muxed in the same loop, which avoids
    // indexing past N when N is not a power of two.
    always_comb begin
        sel_hit  = '0;
        sel_idx  = '0;
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (occ_q[i] && (age_q[i] == '0)) begin
                sel_hit[i] = 1'b1;
                sel_idx    = AGE_W'(i);
                out_data   = data_q[i];
            end
        end
    end

    assign out_vld = |occ_q;
    assign out_idx = sel_idx;
    assign dep     = out_vld && out_rdy;

`ifdef CHOOSE_WITH_AGE_BYPASS_EN
    // The slot being drained may take a new request on the same edge.
    assign in_rdy = rst ? '0 : (~occ_q | (sel_hit & {N{dep}}));
`else
    assign in_rdy = rst ? '0 : ~occ_q;
`endif

    assign acc = in_vld & in_rdy;

    // Arrival ages. Arrivals queue behind every survivor (occ_cnt - dep).
    // Arrivals in the same cycle are ordered lower channel index first. A
    // bypass refill of the drained slot uses the same formula because dep=1
    // in that case.
    always_comb begin
        logic [CNT_W-1:0] run;
        run = occ_cnt - CNT_W'(dep);
        for (int i = 0; i < N; i++) begin
            new_age[i] = run[AGE_W-1:0];
            if (acc[i]) begin
                run = run + CNT_W'(1);
            end
        end
    end

    // State update. Acceptance has priority over departure, which only
    // matters for a bypass refill of the slot being drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
            for (int i = 0; i < N; i++) begin
                age_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    occ_q[i]  <= 1'b1;
                    age_q[i]  <= new_age[i];
                    data_q[i] <= in_data[i*DATA_W +: DATA_W];
                end else if (dep && sel_hit[i]) begin
                    occ_q[i]  <= 1'b0;
                    age_q[i]  <= '0;
                end else if (dep && occ_q[i]) begin
                    age_q[i]  <= age_q[i] - AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_choose_with_age_queue_n.sv
// ---------------------------------------------------------------------------
// tb_choose_with_age_queue_n
//
// Uses two instances:
//   dut  (N=3) directed table vectors and hand-written multi-cycle sequences
//   dut5 (N=5) random traffic against a FIFO-order expected queue
// Inputs are driven on the falling edge. Outputs are sampled #1 later.
// ---------------------------------------------------------------------------
module tb_choose_with_age_queue_n;

`ifdef CHOOSE_WITH_AGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- N=3 instance ----------------
    logic        rst;
    logic [2:0]  in_vld;
    logic [2:0]  in_rdy;
    logic [23:0] in_data;
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic [1:0]  occ_cnt;

    choose_with_age_queue_n #(.N(3), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_idx  (out_idx),
        .occ_cnt  (occ_cnt)
    );

    // ---------------- N=5 instance ----------------
    logic        rst5;
    logic [4:0]  vld5;
    logic [4:0]  rdy5;
    logic [39:0] data5;
    logic        ovld5;
    logic        ordy5;
    logic [7:0]  odata5;
    logic [2:0]  oidx5;
    logic [2:0]  cnt5;

    choose_with_age_queue_n #(.N(5), .DATA_W(8)) dut5 (
        .clk      (clk),
        .rst      (rst5),
        .in_vld   (vld5),
        .in_rdy   (rdy5),
        .in_data  (data5),
        .out_vld  (ovld5),
        .out_rdy  (ordy5),
        .out_data (odata5),
        .out_idx  (oidx5),
        .occ_cnt  (cnt5)
    );

    // ---------------- vectors ----------------
    typedef struct {
        logic        r;
        logic [2:0]  vld;
        logic [23:0] data;
        logic        ordy;
        logic [2:0]  e_rdy;
        logic        e_vld;
        logic [1:0]  e_idx;
        logic [7:0]  e_data;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic r, input logic [2:0] vld,
                                input logic [23:0] data, input logic ordy,
                                input logic [2:0] e_rdy, input logic e_vld,
                                input logic [1:0] e_idx, input logic [7:0] e_data,
                                input logic [1:0] e_cnt);
        vec_t v;
        v.r = r; v.vld = vld; v.data = data; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_idx = e_idx;
        v.e_data = e_data; v.e_cnt = e_cnt;
        return v;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        rst     = v.r;
        in_vld  = v.vld;
        in_data = v.data;
        out_rdy = v.ordy;
        #1;
        check({tag, ".in_rdy"},   32'(in_rdy),   32'(v.e_rdy));
        check({tag, ".out_vld"},  32'(out_vld),  32'(v.e_vld));
        check({tag, ".out_idx"},  32'(out_idx),  32'(v.e_idx));
        check({tag, ".out_data"}, 32'(out_data), 32'(v.e_data));
        check({tag, ".occ_cnt"},  32'(occ_cnt),  32'(v.e_cnt));
    endtask

    // ---------------- scoreboard (N=5) ----------------
    logic [10:0] exp_q [$];   // {channel index[2:0], data[7:0]} in drain order
    logic [4:0]  occ_m;

    task automatic random_phase(input int cycles);
        logic [4:0]  v;
        logic        dr;
        logic [4:0]  e_rdy;
        logic [10:0] head;
        logic [10:0] ent;
        logic [2:0]  age_act;
        occ_m = '0;
        exp_q.delete();
        @(negedge clk);
        rst5 = 1'b0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            v  = 5'($urandom_range(0, 31));
            dr = ($urandom_range(0, 3) != 0);
            if ((cyc / 500) % 2 == 1) begin
                dr = ($urandom_range(0, 3) == 0);   // slow-drain phases keep it near full
            end
            for (int i = 0; i < 5; i++) begin
                data5[i*8 +: 8] = 8'($urandom_range(0, 255));
            end
            vld5  = v;
            ordy5 = dr;
            #1;
            e_rdy = ~occ_m;
            if (BYP && dr && exp_q.size() > 0) begin
                head  = exp_q[0];
                e_rdy = e_rdy | (5'd1 << head[10:8]);
            end
            check("rnd.in_rdy",  32'(rdy5),  32'(e_rdy));
            check("rnd.out_vld", 32'(ovld5), 32'(exp_q.size() != 0));
            check("rnd.occ_cnt", 32'(cnt5),  32'(exp_q.size()));
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                check("rnd.out_idx",  32'(oidx5),  32'(head[10:8]));
                check("rnd.out_data", 32'(odata5), 32'(head[7:0]));
            end else begin
                check("rnd.out_idx0",  32'(oidx5),  32'd0);
                check("rnd.out_data0", 32'(odata5), 32'd0);
            end
            // Queue position k must be exactly the slot's relative age.
            for (int k = 0; k < exp_q.size(); k++) begin
                ent     = exp_q[k];
                age_act = dut5.age_q[ent[10:8]];
                check("rnd.age", 32'(age_act), 32'(k));
            end
            // advance the model: departure first, then arrivals low index first
            if (dr && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                occ_m[head[10:8]] = 1'b0;
            end
            for (int i = 0; i < 5; i++) begin
                if (v[i] && e_rdy[i]) begin
                    exp_q.push_back({3'(i), data5[i*8 +: 8]});
                    occ_m[i] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; in_vld = '0; in_data = '0; out_rdy = 1'b0;
        rst5 = 1'b1; vld5 = '0; data5 = '0; ordy5 = 1'b0;
        repeat (3) @(posedge clk);

        // r, vld, data, ordy | e_rdy, e_vld, e_idx, e_data, e_cnt
        // idle after reset
        tbl[0]  = mk(0, 3'b000, 24'h0,      0, 3'b111, 0, 0, 8'h00, 0);
        tbl[1]  = mk(0, 3'b000, 24'h0,      0, 3'b111, 0, 0, 8'h00, 0);
        tbl[2]  = mk(0, 3'b000, 24'h0,      0, 3'b111, 0, 0, 8'h00, 0);
        // order and stall: ch2, ch0, ch1 arrive on separate cycles
        tbl[3]  = mk(0, 3'b100, 24'hA20000, 0, 3'b111, 0, 0, 8'h00, 0);
        tbl[4]  = mk(0, 3'b001, 24'h0000A0, 0, 3'b011, 1, 2, 8'hA2, 1);
        tbl[5]  = mk(0, 3'b010, 24'h00A100, 0, 3'b010, 1, 2, 8'hA2, 2);
        tbl[6]  = mk(0, 3'b000, 24'h0,      0, 3'b000, 1, 2, 8'hA2, 3);
        tbl[7]  = mk(0, 3'b000, 24'h0,      1, BYP ? 3'b100 : 3'b000, 1, 2, 8'hA2, 3);
        tbl[8]  = mk(0, 3'b000, 24'h0,      1, BYP ? 3'b101 : 3'b100, 1, 0, 8'hA0, 2);
        tbl[9]  = mk(0, 3'b000, 24'h0,      1, BYP ? 3'b111 : 3'b101, 1, 1, 8'hA1, 1);
        tbl[10] = mk(0, 3'b000, 24'h0,      1, 3'b111, 0, 0, 8'h00, 0);
        // simultaneous arrival drains lower index first
        tbl[11] = mk(0, 3'b111, 24'hB2B1B0, 1, 3'b111, 0, 0, 8'h00, 0);
        tbl[12] = mk(0, 3'b000, 24'h0,      1, BYP ? 3'b001 : 3'b000, 1, 0, 8'hB0, 3);
        tbl[13] = mk(0, 3'b000, 24'h0,      1, BYP ? 3'b011 : 3'b001, 1, 1, 8'hB1, 2);
        tbl[14] = mk(0, 3'b000, 24'h0,      1, BYP ? 3'b111 : 3'b011, 1, 2, 8'hB2, 1);
        tbl[15] = mk(0, 3'b000, 24'h0,      1, 3'b111, 0, 0, 8'h00, 0);

        for (int k = 0; k < 16; k++) begin
            run_vec(tbl[k], $sformatf("tbl%0d", k));
        end

        // arrival during drain: ch0 departs while ch2 arrives
        run_vec(mk(0, 3'b011, 24'h00C1C0, 0, 3'b111, 0, 0, 8'h00, 0), "drn1");
        run_vec(mk(0, 3'b100, 24'hC20000, 1, BYP ? 3'b101 : 3'b100, 1, 0, 8'hC0, 2), "drn2");
        run_vec(mk(0, 3'b000, 24'h0,      0, 3'b001, 1, 1, 8'hC1, 2), "drn3");
        check("drn3.age_ch1", 32'(dut.age_q[1]), 32'd0);
        check("drn3.age_ch2", 32'(dut.age_q[2]), 32'd1);
        run_vec(mk(0, 3'b000, 24'h0, 1, BYP ? 3'b011 : 3'b001, 1, 1, 8'hC1, 2), "drn4");
        run_vec(mk(0, 3'b000, 24'h0, 1, BYP ? 3'b111 : 3'b011, 1, 2, 8'hC2, 1), "drn5");
        run_vec(mk(0, 3'b000, 24'h0, 1, 3'b111, 0, 0, 8'h00, 0), "drn6");

        // full and draining while ch0 (oldest) presents new data 0x55
        run_vec(mk(0, 3'b111, 24'hD2D1D0, 0, 3'b111, 0, 0, 8'h00, 0), "byp1");
        run_vec(mk(0, 3'b001, 24'h000055, 1, BYP ? 3'b001 : 3'b000, 1, 0, 8'hD0, 3), "byp2");
        run_vec(mk(0, 3'b000, 24'h0, 1, BYP ? 3'b010 : 3'b001, 1, 1, 8'hD1, BYP ? 2'd3 : 2'd2), "byp3");
        run_vec(mk(0, 3'b000, 24'h0, 1, BYP ? 3'b110 : 3'b011, 1, 2, 8'hD2, BYP ? 2'd2 : 2'd1), "byp4");
        run_vec(mk(0, 3'b000, 24'h0, 1, 3'b111, BYP, 0, BYP ? 8'h55 : 8'h00, BYP ? 2'd1 : 2'd0), "byp5");
        run_vec(mk(0, 3'b000, 24'h0, 1, 3'b111, 0, 0, 8'h00, 0), "byp6");

        // reset mid-operation with two slots held; a request during reset is refused
        run_vec(mk(0, 3'b011, 24'h00E1E0, 0, 3'b111, 0, 0, 8'h00, 0), "rst1");
        run_vec(mk(1, 3'b100, 24'hE20000, 0, 3'b000, 1, 0, 8'hE0, 2), "rst2");
        run_vec(mk(0, 3'b000, 24'h0,      0, 3'b111, 0, 0, 8'h00, 0), "rst3");
        run_vec(mk(0, 3'b000, 24'h0,      1, 3'b111, 0, 0, 8'h00, 0), "rst4");

        // random traffic on the N=5 instance
        random_phase(10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
